mtm_serial_packet_tx: RTL and testbench

Synthesisable, parametrised transmitter for the mtm_alu serial protocol. It buffers words in an internal FIFO and serialises each one onto a single line as a frame: {start=0, flag, DATA_W payload bits MSB first, stop=1}. A flag of 1 marks a command frame and closes a packet; a flag of 0 marks a data frame. It sits between a packet source (test sequencer or on-chip master) and the ALU serial input, and adds programmable bit period and inter-frame/inter-packet gaps.

---
 rtl/mtm_serial_packet_tx.sv | 169 ++++++++++++++++
 tb/tb_mtm_serial_packet_tx.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_serial_packet_tx.sv
// Serial frame transmitter for the mtm_alu link: buffers words in a FIFO and shifts
// each one out as {start, flag, payload MSB first, stop} with programmable bit period and gaps.
module mtm_serial_packet_tx #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int BIT_CYCLES = 1,
   parameter int FRAME_GAP  = 2,
   parameter int PACKET_GAP = 50,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_cmd,
   output logic                          sout,
   output logic                          busy,
   output logic                          pkt_done,
   output logic [CNT_W-1:0]              pkt_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int BW      = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
   localparam int DW      = (DATA_W < 2) ? 1 : $clog2(DATA_W);
   localparam int GAP_MAX = (PACKET_GAP > FRAME_GAP) ? PACKET_GAP : FRAME_GAP;
   localparam int GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] FLAG  = 3'd2;
   localparam logic [2:0] DATA  = 3'd3;
   localparam logic [2:0] STOP  = 3'd4;
   localparam logic [2:0] GAP   = 3'd5;

   logic [DATA_W:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              full;
   logic              push;
   logic              pop;

   logic [2:0]        state;
   logic [BW-1:0]     bit_cnt;
   logic              bit_end;
   logic [DW-1:0]     data_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [DATA_W-1:0] shift;
   logic              is_cmd;

   assign full       = (count == (AW+1)'(FIFO_DEPTH));
   assign in_ready   = !full && !reset;
   assign push       = in_valid && in_ready;
   assign pop        = (state == IDLE) && (count != '0);
   assign fifo_level = count;
   assign busy       = (state != IDLE) || (count != '0);
   assign bit_end    = (bit_cnt == BW'(BIT_CYCLES - 1));

   // Storage has no reset: flushing only needs the pointers and occupancy cleared.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {in_cmd, in_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // One bit period counter shared by every line state of the frame.
   always_ff @(posedge clk) begin
      if (reset || state == IDLE || state == GAP || bit_end)
         bit_cnt <= '0;
      else
         bit_cnt <= bit_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         data_cnt  <= '0;
         gap_cnt   <= '0;
         shift     <= '0;
         is_cmd    <= 1'b0;
         pkt_done  <= 1'b0;
         pkt_count <= '0;
      end else begin
         pkt_done <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  {is_cmd, shift} <= mem[rd_ptr];
                  state           <= START;
               end
            end
            START: begin
               if (bit_end)
                  state <= FLAG;
            end
            FLAG: begin
               if (bit_end) begin
                  data_cnt <= DW'(DATA_W - 1);
                  state    <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift <= shift << 1;
                  if (data_cnt == '0)
                     state <= STOP;
                  else
                     data_cnt <= data_cnt - 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  pkt_done <= is_cmd;
                  if (is_cmd)
                     pkt_count <= pkt_count + 1'b1;
                  // A zero-length gap returns straight to IDLE so the next word can pop at once.
                  if ((is_cmd && PACKET_GAP > 0) || (!is_cmd && FRAME_GAP > 0)) begin
                     gap_cnt <= is_cmd ? GAP_W'(PACKET_GAP - 1) : GAP_W'(FRAME_GAP - 1);
                     state   <= GAP;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The line lags the FSM by one register stage, hence the two-edge start latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         sout <= 1'b1;
      end else begin
         case (state)
            START:   sout <= 1'b0;
            FLAG:    sout <= is_cmd;
            DATA:    sout <= shift[DATA_W-1];
            default: sout <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_mtm_serial_packet_tx.sv
// Scoreboard bench for mtm_serial_packet_tx: three instances (default, slow 4-bit, small counter)
// with frame-decoding monitors that pop expected words pushed by the stimulus tasks.
module tb_mtm_serial_packet_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic a_reset;

   logic       a_valid, a_ready, a_cmd, a_sout, a_busy, a_pkt_done;
   logic [7:0] a_data;
   logic [15:0] a_pkt_count;
   logic [4:0] a_level;

   logic       b_valid, b_ready, b_cmd, b_sout, b_busy, b_pkt_done;
   logic [3:0] b_data;
   logic [15:0] b_pkt_count;
   logic [4:0] b_level;

   logic       c_valid, c_ready, c_cmd, c_sout, c_busy, c_pkt_done;
   logic [7:0] c_data;
   logic [3:0] c_pkt_count;
   logic [4:0] c_level;

   mtm_serial_packet_tx dut_a (
      .clk(clk), .reset(a_reset), .in_valid(a_valid), .in_ready(a_ready),
      .in_data(a_data), .in_cmd(a_cmd), .sout(a_sout), .busy(a_busy),
      .pkt_done(a_pkt_done), .pkt_count(a_pkt_count), .fifo_level(a_level)
   );

   mtm_serial_packet_tx #(.DATA_W(4), .BIT_CYCLES(3), .FRAME_GAP(0)) dut_b (
      .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
      .in_data(b_data), .in_cmd(b_cmd), .sout(b_sout), .busy(b_busy),
      .pkt_done(b_pkt_done), .pkt_count(b_pkt_count), .fifo_level(b_level)
   );

   mtm_serial_packet_tx #(.CNT_W(4), .PACKET_GAP(0)) dut_c (
      .clk(clk), .reset(reset), .in_valid(c_valid), .in_ready(c_ready),
      .in_data(c_data), .in_cmd(c_cmd), .sout(c_sout), .busy(c_busy),
      .pkt_done(c_pkt_done), .pkt_count(c_pkt_count), .fifo_level(c_level)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [8:0] qa [$];
   logic [4:0] qb [$];
   logic [3:0] qc [$];
   int         a_starts [$];
   int         b_starts [$];
   int         a_done_cnt = 0;
   int         c_done = 0;
   bit         a_flush = 1'b0;
   bit         a_saw_full = 1'b0;
   logic [3:0] c_exp = 4'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Offers one word, waits (bounded) for acceptance and records the expectation.
   task automatic applyStimulus(input int dut, input logic [7:0] d, input logic c);
      int   t;
      logic rdy;
      @(negedge clk);
      case (dut)
         0:       begin a_valid = 1'b1; a_data = d;      a_cmd = c; end
         1:       begin b_valid = 1'b1; b_data = d[3:0]; b_cmd = c; end
         default: begin c_valid = 1'b1; c_data = d;      c_cmd = c; end
      endcase
      rdy = (dut == 0) ? a_ready : (dut == 1) ? b_ready : c_ready;
      if (!rdy && dut == 0) begin
         a_saw_full = 1'b1;
         checkOutput("a_ready_low_level", 32'(a_level), 32'd16);
      end
      t = 0;
      while (!rdy && t < 2000) begin
         @(negedge clk);
         t++;
         rdy = (dut == 0) ? a_ready : (dut == 1) ? b_ready : c_ready;
      end
      if (!rdy) begin
         checkOutput("push_timeout", 32'(rdy), 32'd1);
      end else begin
         case (dut)
            0:       qa.push_back({c, d});
            1:       qb.push_back({c, d[3:0]});
            default: begin c_exp = c_exp + 4'd1; qc.push_back(c_exp); end
         endcase
      end
      @(posedge clk);
   endtask

   task automatic releaseInputs();
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      c_valid = 1'b0;
   endtask

   task automatic waitDone(input int dut, input string name);
      int t;
      bit done;
      t = 0;
      done = 1'b0;
      while (!done && t < 5000) begin
         @(negedge clk);
         t++;
         case (dut)
            0:       done = (a_busy === 1'b0) && (qa.size() == 0);
            1:       done = (b_busy === 1'b0) && (qb.size() == 0);
            default: done = (c_busy === 1'b0) && (qc.size() == 0);
         endcase
      end
      checkOutput(name, 32'(done), 32'd1);
   endtask

   // Monitor A: decodes 11-bit frames and matches them against the expected queue.
   logic [9:0] a_frame;
   initial forever begin
      @(negedge clk);
      if (a_reset === 1'b0 && a_sout === 1'b0) begin
         a_starts.push_back(cyc);
         for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            a_frame[i] = a_sout;
         end
         if (a_flush) begin
            a_flush = 1'b0;
         end else if (qa.size() == 0) begin
            checkOutput("a_unexpected_frame", 32'(qa.size()), 32'd1);
         end else begin
            checkOutput("a_frame", 32'(a_frame[9:1]), 32'(qa.pop_front()));
            checkOutput("a_stop_bit", 32'(a_frame[0]), 32'd1);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (a_pkt_done === 1'b1)
         a_done_cnt++;
   end

   // Monitor B: 3-clock bits, checks every bit is held and decodes the 4-bit frame.
   logic [20:0] b_samp;
   bit          b_hold_ok;
   initial forever begin
      @(negedge clk);
      if (reset === 1'b0 && b_sout === 1'b0) begin
         b_starts.push_back(cyc);
         b_samp[0] = b_sout;
         for (int i = 1; i < 21; i++) begin
            @(negedge clk);
            b_samp[i] = b_sout;
         end
         b_hold_ok = 1'b1;
         for (int g = 0; g < 7; g++)
            if (b_samp[3*g] !== b_samp[3*g+1] || b_samp[3*g] !== b_samp[3*g+2])
               b_hold_ok = 1'b0;
         checkOutput("b_bit_hold", 32'(b_hold_ok), 32'd1);
         if (qb.size() == 0)
            checkOutput("b_unexpected_frame", 32'(qb.size()), 32'd1);
         else
            checkOutput("b_frame",
               32'({b_samp[18], b_samp[3], b_samp[6], b_samp[9], b_samp[12], b_samp[15]}),
               32'({1'b1, qb.pop_front()}));
      end
   end

   // Monitor C: every pkt_done must carry the next expected wrapped count.
   initial forever begin
      @(negedge clk);
      if (c_pkt_done === 1'b1) begin
         c_done++;
         if (qc.size() == 0)
            checkOutput("c_unexpected_pkt", 32'(qc.size()), 32'd1);
         else
            checkOutput("c_pkt_count", 32'(c_pkt_count), 32'(qc.pop_front()));
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t;
      int n;
      int done0;
      bit low;

      reset = 1'b1;  a_reset = 1'b1;
      a_valid = 1'b0; a_data = '0; a_cmd = 1'b0;
      b_valid = 1'b0; b_data = '0; b_cmd = 1'b0;
      c_valid = 1'b0; c_data = '0; c_cmd = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_sout", 32'(a_sout), 32'd1);
      checkOutput("rst_busy", 32'(a_busy), 32'd0);
      checkOutput("rst_pkt_done", 32'(a_pkt_done), 32'd0);
      checkOutput("rst_pkt_count", 32'(a_pkt_count), 32'd0);
      checkOutput("rst_level", 32'(a_level), 32'd0);
      checkOutput("rst_in_ready", 32'(a_ready), 32'd0);
      reset = 1'b0;  a_reset = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_rst", 32'(a_ready), 32'd1);

      $display("[TB] latency from push into empty FIFO");
      a_valid = 1'b1; a_data = 8'h5A; a_cmd = 1'b0;
      @(posedge clk);
      qa.push_back(9'h05A);
      @(negedge clk);
      a_valid = 1'b0;
      checkOutput("lat_level_one", 32'(a_level), 32'd1);
      @(negedge clk);
      checkOutput("lat_level_popped", 32'(a_level), 32'd0);
      checkOutput("lat_sout_n1", 32'(a_sout), 32'd1);
      @(negedge clk);
      checkOutput("lat_sout_n2", 32'(a_sout), 32'd0);
      waitDone(0, "lat_done");

      $display("[TB] simultaneous push and pop");
      @(negedge clk);
      a_valid = 1'b1; a_data = 8'h11; a_cmd = 1'b0;
      @(posedge clk);
      qa.push_back(9'h011);
      @(negedge clk);
      a_data = 8'h22;
      checkOutput("pp_level_first", 32'(a_level), 32'd1);
      @(posedge clk);
      qa.push_back(9'h022);
      @(negedge clk);
      a_valid = 1'b0;
      checkOutput("pp_level_same", 32'(a_level), 32'd1);
      waitDone(0, "pp_done");

      $display("[TB] packet A5 3C 01(cmd)");
      a_starts.delete();
      done0 = a_done_cnt;
      applyStimulus(0, 8'hA5, 1'b0);
      applyStimulus(0, 8'h3C, 1'b0);
      applyStimulus(0, 8'h01, 1'b1);
      releaseInputs();
      t = 0;
      while (a_pkt_done !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      checkOutput("t1_pkt_done_seen", 32'(a_pkt_done), 32'd1);
      checkOutput("t1_pkt_count", 32'(a_pkt_count), 32'd1);
      n = 0;
      low = 1'b0;
      while (a_busy === 1'b1 && n < 200) begin
         if (a_sout !== 1'b1) low = 1'b1;
         n++;
         @(negedge clk);
      end
      checkOutput("t1_packet_gap", 32'(n), 32'd50);
      checkOutput("t1_gap_sout_high", 32'(low), 32'd0);
      waitDone(0, "t1_done");
      checkOutput("t1_pkt_done_pulses", 32'(a_done_cnt - done0), 32'd1);
      checkOutput("t1_frame_count", 32'(a_starts.size()), 32'd3);
      if (a_starts.size() == 3) begin
         checkOutput("t1_spacing_1", 32'(a_starts[1] - a_starts[0]), 32'd14);
         checkOutput("t1_spacing_2", 32'(a_starts[2] - a_starts[1]), 32'd14);
      end

      $display("[TB] streaming 20 words");
      a_saw_full = 1'b0;
      for (int i = 0; i < 20; i++)
         applyStimulus(0, 8'(i * 7 + 3), 1'b0);
      releaseInputs();
      checkOutput("t2_ready_dropped", 32'(a_saw_full), 32'd1);
      waitDone(0, "t2_done");

      $display("[TB] reset during 4th payload bit");
      a_starts.delete();
      applyStimulus(0, 8'hF0, 1'b0);
      applyStimulus(0, 8'h0F, 1'b0);
      applyStimulus(0, 8'h55, 1'b0);
      applyStimulus(0, 8'hAA, 1'b1);
      releaseInputs();
      checkOutput("rst_frame_started", 32'(a_starts.size()), 32'd1);
      t = 0;
      while (a_starts.size() > 0 && cyc < a_starts[0] + 5 && t < 100) begin
         @(negedge clk);
         t++;
      end
      checkOutput("rst_pre_level", 32'(a_level), 32'd3);
      a_flush = 1'b1;
      qa.delete();
      a_reset = 1'b1;
      @(negedge clk);
      a_reset = 1'b0;
      checkOutput("rst_mid_sout", 32'(a_sout), 32'd1);
      checkOutput("rst_mid_level", 32'(a_level), 32'd0);
      checkOutput("rst_mid_pkt_count", 32'(a_pkt_count), 32'd0);
      checkOutput("rst_mid_busy", 32'(a_busy), 32'd0);
      repeat (15) @(negedge clk);
      applyStimulus(0, 8'hC3, 1'b0);
      releaseInputs();
      waitDone(0, "rst_recover_done");

      $display("[TB] 4-bit payload, 3 clocks per bit");
      b_starts.delete();
      applyStimulus(1, 8'h09, 1'b0);
      applyStimulus(1, 8'h06, 1'b1);
      releaseInputs();
      waitDone(1, "b_done");
      checkOutput("b_frame_count", 32'(b_starts.size()), 32'd2);
      if (b_starts.size() == 2)
         checkOutput("b_spacing", 32'(b_starts[1] - b_starts[0]), 32'd22);

      $display("[TB] 17 command frames, 4-bit counter");
      for (int i = 0; i < 17; i++)
         applyStimulus(2, 8'(i), 1'b1);
      releaseInputs();
      waitDone(2, "c_done");
      checkOutput("c_pkt_done_pulses", 32'(c_done), 32'd17);
      checkOutput("c_final_count", 32'(c_pkt_count), 32'd1);

      checkOutput("qa_empty", 32'(qa.size()), 32'd0);
      checkOutput("qb_empty", 32'(qb.size()), 32'd0);
      checkOutput("qc_empty", 32'(qc.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
